ex_mem_stage_unit: RTL and testbench

- EX/MEM boundary block of the RV32IM 5-stage pipeline.
- Registers the EX-stage results and control fields into the MEM stage.
- Computes the MEM-stage return address (PC+4).
- Selects a 32-bit MEM-stage result value through a 4:1 mux, using the registered writeback-select code.

---
 rtl/ex_mem_stage_unit.sv | 103 ++++++++++
 tb/tb_ex_mem_stage_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_unit.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_unit
//   EX/MEM pipeline boundary of the RV32IM 5-stage core. Registers the EX
//   results and control fields into MEM, forms the return address
//   (MEM_PC + 4) and selects the MEM-stage result value.
//
// Optional feature macro: EX_MEM_FLUSH_EN
//   When defined, adds a FLUSH input. FLUSH inserts a bubble by clearing the
//   side-effecting controls (reg write enable, store and load control) while
//   every other field still captures normally. Priority:
//   RESET > FLUSH > STALL > capture.
//
// Ports:
//   CLK, RESET           clock; synchronous active-high reset
//   STALL                hold all registers (memory busywait)
//   FLUSH                bubble insert (only with EX_MEM_FLUSH_EN)
//   EX_*                 EX-stage values to be registered
//   DATA_MEM_READ_DATA   data memory read value, used by the result mux
//   MEM_*                registered copies of the EX_* inputs
//   MEM_PC_PLUS_4        MEM_PC + 4, wraps modulo 2^XLEN
//   MEM_RESULT           result mux selected by MEM_WB_VALUE_SELECT
// ---------------------------------------------------------------------------
module ex_mem_stage_unit #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               STALL,
`ifdef EX_MEM_FLUSH_EN
    input  logic               FLUSH,
`endif
    input  logic [XLEN-1:0]    EX_PC,
    input  logic [XLEN-1:0]    EX_ALU_OUT,
    input  logic [XLEN-1:0]    EX_REG_DATA2,
    input  logic [RADDR_W-1:0] EX_REG_WRITE_ADDR,
    input  logic               EX_REG_WRITE_EN,
    input  logic [2:0]         EX_DATA_MEM_WRITE,
    input  logic [3:0]         EX_DATA_MEM_READ,
    input  logic [1:0]         EX_WB_VALUE_SELECT,
    input  logic [XLEN-1:0]    DATA_MEM_READ_DATA,
    output logic [XLEN-1:0]    MEM_PC,
    output logic [XLEN-1:0]    MEM_PC_PLUS_4,
    output logic [XLEN-1:0]    MEM_ALU_OUT,
    output logic [XLEN-1:0]    MEM_REG_DATA2,
    output logic [RADDR_W-1:0] MEM_REG_WRITE_ADDR,
    output logic               MEM_REG_WRITE_EN,
    output logic [2:0]         MEM_DATA_MEM_WRITE,
    output logic [3:0]         MEM_DATA_MEM_READ,
    output logic [1:0]         MEM_WB_VALUE_SELECT,
    output logic [XLEN-1:0]    MEM_RESULT
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            MEM_PC              <= '0;
            MEM_ALU_OUT         <= '0;
            MEM_REG_DATA2       <= '0;
            MEM_REG_WRITE_ADDR  <= '0;
            MEM_REG_WRITE_EN    <= 1'b0;
            MEM_DATA_MEM_WRITE  <= '0;
            MEM_DATA_MEM_READ   <= '0;
            MEM_WB_VALUE_SELECT <= '0;
        end
`ifdef EX_MEM_FLUSH_EN
        // Flush overrides a stall: the bubble must land even while memory is busy.
        else if (FLUSH) begin
            MEM_PC              <= EX_PC;
            MEM_ALU_OUT         <= EX_ALU_OUT;
            MEM_REG_DATA2       <= EX_REG_DATA2;
            MEM_REG_WRITE_ADDR  <= EX_REG_WRITE_ADDR;
            MEM_REG_WRITE_EN    <= 1'b0;
            MEM_DATA_MEM_WRITE  <= '0;
            MEM_DATA_MEM_READ   <= '0;
            MEM_WB_VALUE_SELECT <= EX_WB_VALUE_SELECT;
        end
`endif
        else if (!STALL) begin
            MEM_PC              <= EX_PC;
            MEM_ALU_OUT         <= EX_ALU_OUT;
            MEM_REG_DATA2       <= EX_REG_DATA2;
            MEM_REG_WRITE_ADDR  <= EX_REG_WRITE_ADDR;
            MEM_REG_WRITE_EN    <= EX_REG_WRITE_EN;
            MEM_DATA_MEM_WRITE  <= EX_DATA_MEM_WRITE;
            MEM_DATA_MEM_READ   <= EX_DATA_MEM_READ;
            MEM_WB_VALUE_SELECT <= EX_WB_VALUE_SELECT;
        end
    end

    // Carry out is dropped on purpose so the link value wraps.
    assign MEM_PC_PLUS_4 = MEM_PC + XLEN'(4);

    always_comb begin
        MEM_RESULT = '0;
        case (MEM_WB_VALUE_SELECT)
            2'b00:   MEM_RESULT = MEM_PC_PLUS_4;
            2'b01:   MEM_RESULT = MEM_ALU_OUT;
            2'b10:   MEM_RESULT = DATA_MEM_READ_DATA;
            default: MEM_RESULT = '0;
        endcase
    end

endmodule

// File: tb/tb_ex_mem_stage_unit.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage_unit
//   Directed self-checking bench for ex_mem_stage_unit. Inputs change 1 ns
//   after a rising edge and outputs are sampled at the same point, so every
//   value checked is stable well away from the active edge.
//   Flush steps are compiled in only when EX_MEM_FLUSH_EN is defined.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        STALL;
`ifdef EX_MEM_FLUSH_EN
    logic        FLUSH;
`endif
    logic [31:0] EX_PC;
    logic [31:0] EX_ALU_OUT;
    logic [31:0] EX_REG_DATA2;
    logic [4:0]  EX_REG_WRITE_ADDR;
    logic        EX_REG_WRITE_EN;
    logic [2:0]  EX_DATA_MEM_WRITE;
    logic [3:0]  EX_DATA_MEM_READ;
    logic [1:0]  EX_WB_VALUE_SELECT;
    logic [31:0] DATA_MEM_READ_DATA;
    logic [31:0] MEM_PC;
    logic [31:0] MEM_PC_PLUS_4;
    logic [31:0] MEM_ALU_OUT;
    logic [31:0] MEM_REG_DATA2;
    logic [4:0]  MEM_REG_WRITE_ADDR;
    logic        MEM_REG_WRITE_EN;
    logic [2:0]  MEM_DATA_MEM_WRITE;
    logic [3:0]  MEM_DATA_MEM_READ;
    logic [1:0]  MEM_WB_VALUE_SELECT;
    logic [31:0] MEM_RESULT;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 CLK = ~CLK;

    ex_mem_stage_unit #(.XLEN(32), .RADDR_W(5)) dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .STALL               (STALL),
`ifdef EX_MEM_FLUSH_EN
        .FLUSH               (FLUSH),
`endif
        .EX_PC               (EX_PC),
        .EX_ALU_OUT          (EX_ALU_OUT),
        .EX_REG_DATA2        (EX_REG_DATA2),
        .EX_REG_WRITE_ADDR   (EX_REG_WRITE_ADDR),
        .EX_REG_WRITE_EN     (EX_REG_WRITE_EN),
        .EX_DATA_MEM_WRITE   (EX_DATA_MEM_WRITE),
        .EX_DATA_MEM_READ    (EX_DATA_MEM_READ),
        .EX_WB_VALUE_SELECT  (EX_WB_VALUE_SELECT),
        .DATA_MEM_READ_DATA  (DATA_MEM_READ_DATA),
        .MEM_PC              (MEM_PC),
        .MEM_PC_PLUS_4       (MEM_PC_PLUS_4),
        .MEM_ALU_OUT         (MEM_ALU_OUT),
        .MEM_REG_DATA2       (MEM_REG_DATA2),
        .MEM_REG_WRITE_ADDR  (MEM_REG_WRITE_ADDR),
        .MEM_REG_WRITE_EN    (MEM_REG_WRITE_EN),
        .MEM_DATA_MEM_WRITE  (MEM_DATA_MEM_WRITE),
        .MEM_DATA_MEM_READ   (MEM_DATA_MEM_READ),
        .MEM_WB_VALUE_SELECT (MEM_WB_VALUE_SELECT),
        .MEM_RESULT          (MEM_RESULT)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] d2,
                         input logic [4:0] rd, input logic wen, input logic [2:0] wr,
                         input logic [3:0] rdc, input logic [1:0] sel);
        EX_PC              = pc;
        EX_ALU_OUT         = alu;
        EX_REG_DATA2       = d2;
        EX_REG_WRITE_ADDR  = rd;
        EX_REG_WRITE_EN    = wen;
        EX_DATA_MEM_WRITE  = wr;
        EX_DATA_MEM_READ   = rdc;
        EX_WB_VALUE_SELECT = sel;
    endtask

    initial begin
        // Reset with nonzero EX inputs
        RESET = 1'b1;
        STALL = 1'b0;
`ifdef EX_MEM_FLUSH_EN
        FLUSH = 1'b0;
`endif
        DATA_MEM_READ_DATA = 32'hA5A5A5A5;
        drive(32'h1234, 32'h5678, 32'h9ABC, 5'd31, 1'b1, 3'b111, 4'b1111, 2'b10);
        edge_step();
        edge_step();
        check("rst_pc",    MEM_PC, 32'h0);
        check("rst_alu",   MEM_ALU_OUT, 32'h0);
        check("rst_d2",    MEM_REG_DATA2, 32'h0);
        check("rst_rd",    32'(MEM_REG_WRITE_ADDR), 32'h0);
        check("rst_wen",   32'(MEM_REG_WRITE_EN), 32'h0);
        check("rst_wr",    32'(MEM_DATA_MEM_WRITE), 32'h0);
        check("rst_rdc",   32'(MEM_DATA_MEM_READ), 32'h0);
        check("rst_sel",   32'(MEM_WB_VALUE_SELECT), 32'h0);
        check("rst_pc4",   MEM_PC_PLUS_4, 32'h4);
        check("rst_res",   MEM_RESULT, 32'h4);

        // Basic capture
        RESET = 1'b0;
        drive(32'h100, 32'hDEADBEEF, 32'h55, 5'd7, 1'b1, 3'b010, 4'b0000, 2'b01);
        edge_step();
        check("cap_pc",    MEM_PC, 32'h100);
        check("cap_alu",   MEM_ALU_OUT, 32'hDEADBEEF);
        check("cap_d2",    MEM_REG_DATA2, 32'h55);
        check("cap_rd",    32'(MEM_REG_WRITE_ADDR), 32'd7);
        check("cap_wen",   32'(MEM_REG_WRITE_EN), 32'd1);
        check("cap_wr",    32'(MEM_DATA_MEM_WRITE), 32'b010);
        check("cap_rdc",   32'(MEM_DATA_MEM_READ), 32'b0000);
        check("cap_sel",   32'(MEM_WB_VALUE_SELECT), 32'b01);
        check("cap_pc4",   MEM_PC_PLUS_4, 32'h104);
        check("cap_res",   MEM_RESULT, 32'hDEADBEEF);

        // Mux legs
        DATA_MEM_READ_DATA = 32'hCAFEF00D;
        drive(32'h200, 32'h11, 32'h0, 5'd1, 1'b1, 3'b000, 4'b0000, 2'b00);
        edge_step();
        check("mux_00",    MEM_RESULT, 32'h204);
        EX_WB_VALUE_SELECT = 2'b01;
        edge_step();
        check("mux_01",    MEM_RESULT, 32'h11);
        EX_WB_VALUE_SELECT = 2'b10;
        edge_step();
        check("mux_10",    MEM_RESULT, 32'hCAFEF00D);
        DATA_MEM_READ_DATA = 32'h12345678;
        #1;
        check("mux_10_upd", MEM_RESULT, 32'h12345678);
        EX_WB_VALUE_SELECT = 2'b11;
        edge_step();
        check("mux_11",    MEM_RESULT, 32'h0);
        check("mux_11_pc", MEM_PC, 32'h200);

        // Stall holds while EX inputs change
        drive(32'h300, 32'h33, 32'h77, 5'd3, 1'b1, 3'b001, 4'b0010, 2'b01);
        edge_step();
        check("pre_stall_pc", MEM_PC, 32'h300);
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'h400 + 32'(i), 32'h40 + 32'(i), 32'h90 + 32'(i), 5'd9, 1'b0,
                  3'b100, 4'b1000, 2'b10);
            edge_step();
            check("stall_pc",  MEM_PC, 32'h300);
            check("stall_alu", MEM_ALU_OUT, 32'h33);
            check("stall_wen", 32'(MEM_REG_WRITE_EN), 32'd1);
            check("stall_res", MEM_RESULT, 32'h33);
        end
        STALL = 1'b0;
        drive(32'h500, 32'h55, 32'h66, 5'd5, 1'b0, 3'b000, 4'b0100, 2'b01);
        edge_step();
        check("unstall_pc",  MEM_PC, 32'h500);
        check("unstall_rdc", 32'(MEM_DATA_MEM_READ), 32'b0100);
        check("unstall_res", MEM_RESULT, 32'h55);

        // Reset while stalled, then capture only at the next unstalled edge
        STALL = 1'b1;
        RESET = 1'b1;
        edge_step();
        check("rst_stall_pc",  MEM_PC, 32'h0);
        check("rst_stall_rdc", 32'(MEM_DATA_MEM_READ), 32'h0);
        check("rst_stall_res", MEM_RESULT, 32'h4);
        RESET = 1'b0;
        drive(32'h600, 32'h66, 32'h0, 5'd6, 1'b1, 3'b000, 4'b0000, 2'b01);
        edge_step();
        check("post_rst_hold", MEM_PC, 32'h0);
        STALL = 1'b0;
        edge_step();
        check("post_rst_cap",  MEM_PC, 32'h600);

        // PC+4 wrap
        drive(32'hFFFFFFFC, 32'h1, 32'h0, 5'd1, 1'b1, 3'b000, 4'b0000, 2'b00);
        edge_step();
        check("wrap_pc4", MEM_PC_PLUS_4, 32'h0);
        check("wrap_res", MEM_RESULT, 32'h0);

`ifdef EX_MEM_FLUSH_EN
        FLUSH = 1'b1;
        drive(32'h40, 32'h44, 32'h88, 5'd4, 1'b1, 3'b001, 4'b0100, 2'b01);
        edge_step();
        check("flush_wen", 32'(MEM_REG_WRITE_EN), 32'd0);
        check("flush_wr",  32'(MEM_DATA_MEM_WRITE), 32'd0);
        check("flush_rdc", 32'(MEM_DATA_MEM_READ), 32'd0);
        check("flush_pc",  MEM_PC, 32'h40);
        check("flush_alu", MEM_ALU_OUT, 32'h44);
        FLUSH = 1'b0;
        edge_step();
        check("noflush_wen", 32'(MEM_REG_WRITE_EN), 32'd1);
        FLUSH = 1'b1;
        STALL = 1'b1;
        drive(32'h80, 32'h88, 32'h0, 5'd8, 1'b1, 3'b010, 4'b0001, 2'b01);
        edge_step();
        check("flush_stall_pc",  MEM_PC, 32'h80);
        check("flush_stall_wen", 32'(MEM_REG_WRITE_EN), 32'd0);
        check("flush_stall_wr",  32'(MEM_DATA_MEM_WRITE), 32'd0);
        FLUSH = 1'b0;
        STALL = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
